prio_enc_rr: RTL and testbench
==============================

# prio_enc_rr

Parametrised, registered priority encoder with request buffering and a valid/ready output handshake. It generalises the 10-line BCD encoder to N request lines and adds a round-robin mode. Requests are latched into a pending register, so no pulse is lost while the consumer stalls. It sits between interrupt- or request-style sources and a single sequential consumer that takes one index at a time.

## Interface
- N, 10, number of request lines; N ≥ 2.
- W, 4, output index width; 2^W ≥ N required (elaboration error otherwise).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  when 1, req is sampled into the pending register; when 0, req is ignored.
- mode  input  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- req  input  N  request lines, level-sampled each cycle.
- out  output  W  encoded index of the granted request.
- out_valid  output  1  out holds an unaccepted grant.
- out_ready  input  1  consumer accepts out when out_valid & out_ready at a rising edge.
- busy  output  1  combinational: |pend | out_valid.
- drop  output  1  registered one-cycle pulse: at least one request merged into an already-pending bit.

## Operation
- **pend[N-1:0].** Holds requests not yet granted.
  - Update rule: pend_next = (pend & ~sel_oh_if_load) | (enable ? req : 0).
  - Set wins. A req on the bit being granted this cycle is re-latched and granted again later.
- **Load condition.** load = (|pend) & (!out_valid | out_ready).
- **On load:**
  - out ← index of the selected bit.
  - out_valid ← 1.
  - The selected bit is cleared from pend.
- **Drain.** If out_valid & out_ready and pend is empty, then out_valid ← 0. out holds its last value. Consumers must ignore out while out_valid = 0.
- **Fixed mode (mode=0).** Select the lowest set index of pend, with no regard to ptr. This matches the legacy priority ordering.
- **Round-robin mode (mode=1).**
  - Select the lowest set index ≥ ptr. If none exists, wrap and select the lowest set index < ptr.
- **ptr.**
  - Width W, range 0..N-1.
  - On every load (either mode), ptr ← (selected index + 1) mod N. When index N-1 is selected, ptr wraps to 0.
- **mode change.** Takes effect at the next load. An in-flight out is unaffected.
- **drop.** Registered pulse, 1 for one cycle after an edge at which enable & req[i] & pend[i] & !(load & sel==i) held for some i. The merged request is lost; the grant count for bit i is one.
- **enable=0.** Pending requests still drain normally.

## Timing
- **Reset values (asynchronous):**
  - pend = 0, ptr = 0.
  - out = 0, out_valid = 0, drop = 0.
  - busy = 0.
- **Latency, idle block.** req high during cycle k is latched at edge k. out/out_valid are valid after edge k+1, i.e. 2 cycles from req to out_valid.
- **Throughput.** One grant per cycle while out_ready = 1 and pend is non-empty. out_valid then stays high continuously.
- **Stall.** While out_valid & !out_ready, out and out_valid are held stable. No load occurs, and pend keeps accumulating.
- **Same-edge acceptance and load.** If out_valid & out_ready and pend is non-empty at the same edge, the next grant replaces out in that cycle with no bubble.
- **Reset mid-operation.** Pending requests and any unaccepted out are discarded immediately, and ptr returns to 0. The first grant after rst deasserts follows the 2-cycle latency.
- **No combinational paths.** There is no combinational path from req, enable or mode to out or out_valid. busy is the only combinational output.

## Test plan
- **Fixed mode, basic.** N=10, mode=0, out_ready=1, enable=1; req=10'b0000100100 for one cycle.
  - out_valid goes high 2 cycles later.
  - out=2, then out=5 on the next cycle.
  - out_valid then falls and busy returns to 0.
- **Round-robin fairness.** mode=1, req=10'b1000000011 held high continuously, out_ready=1.
  - Grant sequence is 0, 1, 9, 0, 1, 9, …
  - ptr wraps 9→0, and drop pulses on the cycles where held bits merge.
- **Stall and buffering.** out_ready=0; pulse req[3] for one cycle, then req[7] for one cycle.
  - out=3 and out_valid are held stable for 5 stalled cycles.
  - Raise out_ready: out=7 appears the next cycle, then out_valid falls.
- **Merge and set-wins.** req[4] pulsed twice while out stalls on another grant.
  - drop pulses once and only one grant of 4 is produced.
  - req[4] asserted on the exact edge where 4 is loaded re-latches, giving a second grant of 4.
- **enable gating.** enable=0 with req=all ones.
  - No grants occur and busy=0.
  - Existing pending bits still drain when enable=0 is applied mid-stream.
- **Asynchronous reset.** Assert rst between clock edges with pend=10'b1111111111 and out_valid=1.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a single req[6] pulse yields out=6 at 2-cycle latency, with ptr restarting from 0.

Source files
------------

// File: rtl/prio_enc_rr_if.sv
// Request/grant bundle for prio_enc_rr: request side inputs, encoded index stream out,
// plus the internal pointer and pending vector as read-only debug taps.
interface prio_enc_rr_if #(
  parameter int N = 10,
  parameter int W = 4
);
  logic         enable;
  logic         mode;
  logic [N-1:0] req;

  // out/out_valid/out_ready: valid/ready stream. Once out_valid is high, out and out_valid
  // stay stable until a rising edge sees out_valid & out_ready; that edge is the transfer.
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;

  logic         busy;
  logic         drop;
  logic [W-1:0] dbg_ptr;
  logic [N-1:0] dbg_pend;

  modport master (
    input  enable, mode, req, out_ready,
    output out, out_valid, busy, drop, dbg_ptr, dbg_pend
  );

  modport slave (
    output enable, mode, req, out_ready,
    input  out, out_valid, busy, drop, dbg_ptr, dbg_pend
  );
endinterface

// File: rtl/prio_enc_rr.sv
// Registered N-line priority encoder with pending-request buffering, fixed or
// round-robin selection, and a valid/ready output stream.
module prio_enc_rr #(
  parameter int N = 10,
  parameter int W = 4
) (
  input logic           clk,
  input logic           rst,
  prio_enc_rr_if.master bus
);

  if ((1 << W) < N) begin : g_bad_width
    $error("prio_enc_rr: W too small to encode N request lines");
  end
  if (N < 2) begin : g_bad_n
    $error("prio_enc_rr: N must be at least 2");
  end

  logic [N-1:0] pend, pend_nxt;
  logic [N-1:0] req_in;
  logic [N-1:0] sel_oh;
  logic [W-1:0] ptr, ptr_nxt;
  logic [W-1:0] sel_idx;
  logic [W-1:0] out_q, out_nxt;
  logic         out_valid_q, out_valid_nxt;
  logic         drop_q, drop_nxt;
  logic         load;
  logic         found;

  assign req_in = bus.enable ? bus.req : '0;
  assign load   = (|pend) && (!out_valid_q || bus.out_ready);

  // Round-robin first scans [ptr, N-1]; the second pass covers the wrap and fixed mode.
  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    if (bus.mode) begin
      for (int i = 0; i < N; i++) begin
        if (!found && pend[i] && (W'(i) >= ptr)) begin
          sel_idx = W'(i);
          found   = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && pend[i]) begin
        sel_idx = W'(i);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    sel_oh        = load ? (N'(1) << sel_idx) : '0;
    // Set wins: a request on the bit granted this cycle is re-latched.
    pend_nxt      = (pend & ~sel_oh) | req_in;
    drop_nxt      = |(req_in & pend & ~sel_oh);
    ptr_nxt       = ptr;
    out_nxt       = out_q;
    out_valid_nxt = out_valid_q;
    if (load) begin
      out_nxt       = sel_idx;
      out_valid_nxt = 1'b1;
      ptr_nxt       = (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend        <= '0;
      ptr         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      pend        <= pend_nxt;
      ptr         <= ptr_nxt;
      out_q       <= out_nxt;
      out_valid_q <= out_valid_nxt;
      drop_q      <= drop_nxt;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (|pend) | out_valid_q;
  assign bus.drop      = drop_q;
  assign bus.dbg_ptr   = ptr;
  assign bus.dbg_pend  = pend;

endmodule

// File: tb/tb_prio_enc_rr.sv
// Bench for prio_enc_rr: directed scenarios plus random traffic, all checked cycle by
// cycle against a behavioural model and a grant scoreboard.
module tb_prio_enc_rr;
  localparam int N = 10;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;

  prio_enc_rr_if #(.N(N), .W(W)) bus ();
  prio_enc_rr #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  bit m_pend[N];
  int m_ptr;
  int m_out;
  bit m_valid;
  bit m_drop;

  logic [W-1:0] exp_q[$];
  int           grant_log[$];
  int           drop_cnt;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pend_vec();
    int v = 0;
    for (int i = 0; i < N; i++) if (m_pend[i]) v |= (1 << i);
    return v;
  endfunction

  // Scan N positions starting at base, wrapping modulo N.
  function automatic int pick(input int base);
    for (int k = 0; k < N; k++) begin
      int idx = (base + k) % N;
      if (m_pend[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_ptr = 0; m_out = 0; m_valid = 1'b0; m_drop = 1'b0;
    exp_q.delete();
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    bit acc;
    int acc_out;
    int sel;
    bit ld;
    bit new_pend[N];
    acc     = bus.out_valid && bus.out_ready;
    acc_out = bus.out;
    @(posedge clk);
    ld  = (pend_vec() != 0) && (!m_valid || bus.out_ready);
    sel = ld ? pick(bus.mode ? m_ptr : 0) : -1;
    m_drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.enable && bus.req[i] && m_pend[i] && i != sel) m_drop = 1'b1;
      new_pend[i] = (m_pend[i] && i != sel) || (bus.enable && bus.req[i]);
    end
    if (ld) begin
      exp_q.push_back(W'(sel));
      m_out   = sel;
      m_valid = 1'b1;
      m_ptr   = (sel + 1) % N;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
    m_pend = new_pend;
    #1;
    if (acc) begin
      grant_log.push_back(acc_out);
      if (exp_q.size() == 0) check("grant_unexpected", acc_out, -1);
      else check("grant", acc_out, int'(exp_q.pop_front()));
    end
    if (bus.drop) drop_cnt++;
    check("out_valid", bus.out_valid, m_valid);
    check("out", bus.out, m_out);
    check("drop", bus.drop, m_drop);
    check("busy", bus.busy, (pend_vec() != 0) || m_valid);
    check("ptr", bus.dbg_ptr, m_ptr);
    check("pend", bus.dbg_pend, pend_vec());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_drop", bus.drop, 0);
    check("rst_ptr", bus.dbg_ptr, 0);
    rst = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.enable    = 1'b1;
    bus.mode      = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b1;
    drop_cnt      = 0;
    do_reset();

    // Fixed mode basic
    grant_log.delete();
    bus.req = 10'b0000100100;
    step();
    bus.req = '0;
    check("basic_lat_v0", bus.out_valid, 0);
    step();
    check("basic_v1", bus.out_valid, 1);
    check("basic_out2", bus.out, 2);
    step();
    check("basic_out5", bus.out, 5);
    step();
    check("basic_v_fall", bus.out_valid, 0);
    check("basic_busy0", bus.busy, 0);
    steps(2);
    check("basic_log_n", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("basic_log0", grant_log[0], 2);
      check("basic_log1", grant_log[1], 5);
    end

    // Round-robin fairness from ptr = 0
    do_reset();
    grant_log.delete();
    drop_cnt = 0;
    bus.mode = 1'b1;
    bus.req  = 10'b1000000011;
    steps(12);
    bus.req = '0;
    steps(5);
    check("rr_log_n_ge6", grant_log.size() >= 6, 1);
    if (grant_log.size() >= 6) begin
      check("rr_g0", grant_log[0], 0);
      check("rr_g1", grant_log[1], 1);
      check("rr_g2", grant_log[2], 9);
      check("rr_g3", grant_log[3], 0);
      check("rr_g4", grant_log[4], 1);
      check("rr_g5", grant_log[5], 9);
    end
    check("rr_drops_seen", drop_cnt > 0, 1);

    // Stall and buffering
    grant_log.delete();
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
    bus.req = 10'b0000001000;
    step();
    bus.req = 10'b0010000000;
    step();
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_out3", bus.out, 3);
      check("stall_v", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    step();
    check("stall_out7", bus.out, 7);
    step();
    check("stall_v_fall", bus.out_valid, 0);
    check("stall_log_n", grant_log.size(), 2);

    // Merge while stalled, then set-wins re-latch
    grant_log.delete();
    bus.out_ready = 1'b0;
    bus.req = 10'b0000000100;
    step();
    bus.req = '0;
    step();
    bus.req = 10'b0000010000;
    step();
    bus.req = '0;
    step();
    check("merge_nodrop_yet", bus.drop, 0);
    bus.req = 10'b0000010000;
    step();
    bus.req = '0;
    check("merge_drop", bus.drop, 1);
    step();
    check("merge_drop_onecycle", bus.drop, 0);
    bus.out_ready = 1'b1;
    steps(4);
    check("merge_log_n", grant_log.size(), 2);
    grant_log.delete();
    bus.req = 10'b0000010000;
    step();
    step();
    check("setwins_nodrop", bus.drop, 0);
    bus.req = '0;
    steps(4);
    check("setwins_two_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) check("setwins_second_is_4", grant_log[1], 4);

    // enable gating
    grant_log.delete();
    bus.enable = 1'b0;
    bus.req    = '1;
    steps(4);
    check("en0_busy", bus.busy, 0);
    check("en0_no_grants", grant_log.size(), 0);
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    steps(13);
    check("en0_drain_n", grant_log.size(), N);
    check("en0_drained_busy", bus.busy, 0);

    // Asynchronous reset mid-operation
    bus.enable    = 1'b1;
    bus.out_ready = 1'b0;
    bus.req       = '1;
    steps(2);
    check("pre_rst_pend_full", bus.dbg_pend, (1 << N) - 1);
    check("pre_rst_valid", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out", bus.out, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_pend", bus.dbg_pend, 0);
    check("arst_ptr", bus.dbg_ptr, 0);
    model_reset();
    bus.req = '0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    grant_log.delete();
    bus.req = 10'b0001000000;
    step();
    bus.req = '0;
    check("arst_lat_v0", bus.out_valid, 0);
    step();
    check("arst_out6", bus.out, 6);
    check("arst_ptr7", bus.dbg_ptr, 7);
    steps(2);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      bus.req       = N'($urandom & $urandom & $urandom);
      bus.enable    = ($urandom_range(0, 9) != 0);
      bus.mode      = ($urandom_range(0, 19) == 0) ? ~bus.mode : bus.mode;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.req       = '0;
    bus.out_ready = 1'b1;
    steps(N + 4);
    check("final_idle", bus.busy, 0);
    check("final_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
